// File: rtl/mv_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mv_uart_pkg
// Brief    : Shared types and helpers for the UART transmit arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package mv_uart_pkg;

    // Arbiter FSM states; HDR is only reachable when the header build option is on
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        XFER = 2'd2,
        COOL = 2'd3
    } arb_state_t;

    // Upper nibble of the per-grant header byte
    localparam logic [3:0] UART_HDR_MAGIC = 4'hA;

    // Ceiling log2 for elaboration-time width calculation
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : mv_uart_pkg
`default_nettype wire

// File: rtl/mv_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : mv_rr_picker
// Brief    : Combinational round-robin find-first. Returns the first set bit
//            of req searching upward from ptr+1 and wrapping to bit 0.
// Revision : 1.0 - initial release
// ============================================================================
module mv_rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [3:0]         ptr,
    output logic [3:0]         idx,
    output logic               any
);

    // Two passes: bits strictly above ptr first, then the wrapped range 0..ptr
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (4'(i) > ptr)) begin
                any = 1'b1;
                idx = 4'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (4'(i) <= ptr)) begin
                any = 1'b1;
                idx = 4'(i);
            end
        end
    end

endmodule : mv_rr_picker
`default_nettype wire

// File: rtl/mv_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mv_uart_tx_arbiter
// Brief    : Round-robin sharing of the UART transmit byte path among NUM_REQ
//            requesters. A grant is held until the requester's last byte (or
//            until MAX_MSG_LEN bytes), so messages never interleave.
//            Build option MV_UART_ARB_HDR_EN: prefix each grant with a header
//            byte {UART_HDR_MAGIC, grant_id}.
// Revision : 1.0 - initial release
// ============================================================================
module mv_uart_tx_arbiter
    import mv_uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MAX_MSG_LEN = 64
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             uart_data,
    output logic                   uart_req,
    input  logic                   uart_ready,
    output logic [3:0]             grant_id,
    output logic                   busy,
    output logic                   arb_overrun
);

    localparam int                 c_CNT_W     = (MAX_MSG_LEN == 0) ? 1 : clog2(MAX_MSG_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LIMIT = (MAX_MSG_LEN == 0) ? {c_CNT_W{1'b1}}
                                                                    : c_CNT_W'(MAX_MSG_LEN);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = 1;
    localparam logic [3:0]         c_LAST_ID   = 4'(NUM_REQ - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [3:0]           r_rr_ptr;
    logic [c_CNT_W-1:0]   r_byte_cnt;
    logic                 r_last_byte;

    logic [3:0]           w_pick_idx;
    logic                 w_pick_any;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic [7:0]           w_sel_data;
    logic                 w_accept;
    logic                 w_hdr_wr;
    logic                 w_release;
    logic                 w_force;
    logic                 w_grant_load;

    mv_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req (req_valid),
        .ptr (r_rr_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    // Route the currently granted requester's lane onto a single byte path
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 4'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[8*i +: 8];
            end
        end
    end

    // Next-state, accept strobes and the combinational ready back to requesters
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_hdr_wr    = 1'b0;
        w_release   = 1'b0;
        w_force     = 1'b0;
        req_ready   = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
`ifdef MV_UART_ARB_HDR_EN
                    w_state_nxt = HDR;
`else
                    w_state_nxt = XFER;
`endif
                end
            end
`ifdef MV_UART_ARB_HDR_EN
            HDR: begin
                if (uart_ready) begin
                    w_hdr_wr    = 1'b1;
                    w_state_nxt = COOL;
                end
            end
`endif
            XFER: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_id == 4'(i)) begin
                        req_ready[i] = uart_ready;
                    end
                end
                if (w_sel_valid && uart_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = COOL;
                end
            end
            COOL: begin
                // A natural end of message takes precedence over the length limit
                if (r_last_byte) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end else if ((MAX_MSG_LEN != 0) && (r_byte_cnt == c_CNT_LIMIT)) begin
                    w_release   = 1'b1;
                    w_force     = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = XFER;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_grant_load = (r_state == IDLE) && w_pick_any;
    assign busy         = (r_state != IDLE);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant bookkeeping, byte counter and the registered UART write port
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uart_data   <= '0;
            uart_req    <= 1'b0;
            grant_id    <= '0;
            arb_overrun <= 1'b0;
            r_byte_cnt  <= '0;
            r_last_byte <= 1'b0;
            r_rr_ptr    <= c_LAST_ID;
        end else begin
            uart_req    <= w_accept | w_hdr_wr;
            arb_overrun <= w_force;
            if (w_grant_load) begin
                grant_id    <= w_pick_idx;
                r_byte_cnt  <= '0;
                r_last_byte <= 1'b0;
            end
            if (w_accept) begin
                uart_data   <= w_sel_data;
                r_last_byte <= w_sel_last;
                if (r_byte_cnt != c_CNT_LIMIT) begin
                    r_byte_cnt <= r_byte_cnt + c_CNT_ONE;
                end
            end
            if (w_hdr_wr) begin
                uart_data   <= {UART_HDR_MAGIC, grant_id};
                r_last_byte <= 1'b0;
            end
            if (w_release) begin
                r_rr_ptr <= grant_id;
            end
        end
    end

endmodule : mv_uart_tx_arbiter
`default_nettype wire

// File: tb/tb_mv_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mv_uart_tx_arbiter
// Brief    : Scoreboard bench for mv_uart_tx_arbiter (NUM_REQ=4, MAX_MSG_LEN=4).
//            Honours MV_UART_ARB_HDR_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mv_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int MAX_LEN = 4;
`ifdef MV_UART_ARB_HDR_EN
    localparam int HDR_N = 1;
`else
    localparam int HDR_N = 0;
`endif

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           uart_data;
    logic                 uart_req;
    logic                 uart_ready;
    logic [3:0]           grant_id;
    logic                 busy;
    logic                 arb_overrun;

    always #5 clock = ~clock;

    mv_uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .MAX_MSG_LEN (MAX_LEN)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .uart_data   (uart_data),
        .uart_req    (uart_req),
        .uart_ready  (uart_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .arb_overrun (arb_overrun)
    );

    int checks = 0;
    int errors = 0;

    // stim_q: bytes each requester still has to offer; exp_q: bytes the UART must still see
    logic [8:0] stim_q [NUM_REQ][$];
    logic [8:0] exp_q  [NUM_REQ][$];

    bit   gaps_en   = 1'b0;
    bit   rdy_rand  = 1'b0;
    bit   hold_low  = 1'b0;
    int   wr_count  = 0;
    int   ov_count  = 0;
    int   cycle     = 0;
    int   wr_cycles [$];
    logic [7:0] wr_data [$];
    int   grant_log [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic l);
        stim_q[r].push_back({l, d});
        exp_q[r].push_back({l, d});
    endtask

    // Reference round-robin: first valid requester after the previous winner
    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Requester/UART drivers: retire accepted bytes, then present the next ones
    initial begin
        logic [NUM_REQ-1:0] acc;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        uart_ready = 1'b1;
        forever begin
            @(negedge clock);
            acc = req_valid & req_ready;
            @(posedge clock);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && stim_q[i].size() > 0) void'(stim_q[i].pop_front());
            end
            uart_ready = hold_low ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stim_q[i].size() > 0 && (!gaps_en || $urandom_range(0, 3) != 0)) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = stim_q[i][0][7:0];
                    req_last[i]        = stim_q[i][0][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'($urandom);
                    req_last[i]        = 1'($urandom);
                end
            end
        end
    end

    // Monitor state
    bit                 m_prev_busy  = 1'b0;
    bit                 m_prev_req   = 1'b0;
    bit                 m_prev_ready = 1'b0;
    int                 m_ptr        = NUM_REQ - 1;
    int                 m_grant      = 0;
    int                 m_seg_cnt    = 0;
    bit                 m_seg_last   = 1'b0;
    bit                 m_ov         = 1'b0;
    bit                 m_hdr_pend   = 1'b0;
    logic [NUM_REQ-1:0] m_idle_valid = '0;

    // Monitor: pops the scoreboard on every UART write and checks grant rules
    always @(negedge clock) begin
        logic [8:0]         e;
        logic [NUM_REQ-1:0] allowed;
        if (!reset_n) begin
            m_prev_busy  = 1'b0;
            m_prev_req   = 1'b0;
            m_prev_ready = 1'b0;
            m_ptr        = NUM_REQ - 1;
            m_seg_cnt    = 0;
            m_seg_last   = 1'b0;
            m_ov         = 1'b0;
            m_hdr_pend   = 1'b0;
            m_idle_valid = '0;
        end else begin
            cycle++;
            if (busy && !m_prev_busy) begin
                chk("grant_id", 32'(grant_id), 32'(rr_pick(m_idle_valid, m_ptr)));
                m_grant    = int'(grant_id);
                m_seg_cnt  = 0;
                m_seg_last = 1'b0;
                m_ov       = 1'b0;
                m_hdr_pend = (HDR_N != 0);
                grant_log.push_back(m_grant);
            end else if (busy) begin
                chk("grant_stable", 32'(grant_id), 32'(m_grant));
            end
            if (busy || m_prev_busy) m_ov = m_ov | arb_overrun;
            else chk("overrun_idle", 32'(arb_overrun), 32'd0);

            if (uart_req) begin
                chk("req_pulse_spacing", 32'(m_prev_req), 32'd0);
                chk("req_after_ready", 32'(m_prev_ready), 32'd1);
                chk("req_while_granted", 32'(busy), 32'd1);
                wr_count++;
                wr_cycles.push_back(cycle);
                wr_data.push_back(uart_data);
                if (m_hdr_pend) begin
                    chk("header_byte", 32'(uart_data), {24'd0, 4'hA, 4'(m_grant)});
                    m_hdr_pend = 1'b0;
                end else if (m_grant >= NUM_REQ || exp_q[m_grant].size() == 0) begin
                    chk("unexpected_write", 32'(uart_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q[m_grant].pop_front();
                    chk("data", 32'(uart_data), 32'(e[7:0]));
                    m_seg_cnt++;
                    m_seg_last = e[8];
                    chk("seg_len_bound", 32'(m_seg_cnt <= MAX_LEN), 32'd1);
                end
            end

            if (!busy && m_prev_busy) begin
                chk("release_reason", 32'(m_seg_last || m_seg_cnt == MAX_LEN), 32'd1);
                chk("overrun", 32'(m_ov), 32'(!m_seg_last && m_seg_cnt == MAX_LEN));
                if (m_ov) ov_count++;
                m_ptr = m_grant;
            end

            allowed = busy ? NUM_REQ'(1 << m_grant) : '0;
            chk("ready_mask", 32'(req_ready & ~allowed), 32'd0);
            if (!uart_ready) chk("ready_when_full", 32'(req_ready), 32'd0);

            if (!busy) m_idle_valid = req_valid;
            m_prev_busy  = busy;
            m_prev_req   = uart_req;
            m_prev_ready = uart_ready;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_uart_req"},    32'(uart_req),    32'd0);
        chk({tag, "_uart_data"},   32'(uart_data),   32'd0);
        chk({tag, "_req_ready"},   32'(req_ready),   32'd0);
        chk({tag, "_grant_id"},    32'(grant_id),    32'd0);
        chk({tag, "_busy"},        32'(busy),        32'd0);
        chk({tag, "_arb_overrun"}, 32'(arb_overrun), 32'd0);
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n;
        n = 0;
        while (wr_count < target && n < budget) begin
            @(posedge clock);
            n++;
        end
        chk("wait_writes_timeout", 32'(wr_count >= target), 32'd1);
    endtask

    task automatic wait_grants(input int target, input int budget);
        int n;
        n = 0;
        while (grant_log.size() < target && n < budget) begin
            @(posedge clock);
            n++;
        end
        chk("wait_grant_timeout", 32'(grant_log.size() >= target), 32'd1);
    endtask

    function automatic bit all_drained();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_q[i].size() != 0 || stim_q[i].size() != 0) return 1'b0;
        end
        return !busy;
    endfunction

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!all_drained() && n < budget) begin
            @(posedge clock);
            n++;
        end
        chk("drain_timeout", 32'(all_drained()), 32'd1);
        repeat (2) @(posedge clock);
    endtask

    // Test sequence
    initial begin
        int wc, g0, oc, n;
        logic [7:0] b;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        check_reset_outputs("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);

        // Single 3-byte message at full rate
        wc = wr_count;
        push_byte(0, 8'h11, 1'b0);
        push_byte(0, 8'h22, 1'b0);
        push_byte(0, 8'h33, 1'b1);
        wait_writes(wc + 3 + HDR_N, 200);
        for (int k = wc + 1; k < wc + 3 + HDR_N; k++) begin
            chk("write_spacing", 32'(wr_cycles[k] - wr_cycles[k-1]), 32'd2);
        end
        wait_idle(200);
        chk("busy_after_msg", 32'(busy), 32'd0);

        // Two competing 2-byte messages
        g0 = grant_log.size();
        push_byte(1, 8'hA1, 1'b0);
        push_byte(1, 8'hA2, 1'b1);
        push_byte(2, 8'hB1, 1'b0);
        push_byte(2, 8'hB2, 1'b1);
        wait_idle(300);
        wait_grants(g0 + 2, 10);
        chk("order_first",  32'(grant_log[g0]),     32'd1);
        chk("order_second", 32'(grant_log[g0 + 1]), 32'd2);

        // UART back-pressure mid-message
        wc = wr_count;
        for (int k = 0; k < 5; k++) push_byte(1, 8'(8'h60 + k), (k == 4));
        wait_writes(wc + 2 + HDR_N, 200);
        hold_low = 1'b1;
        wc = wr_count;
        repeat (20) @(posedge clock);
        chk("writes_during_hold", 32'(wr_count - wc), 32'd0);
        hold_low = 1'b0;
        wait_idle(300);

        // Length limit forces release; pending requester 3 gets the next grant
        g0 = grant_log.size();
        oc = ov_count;
        for (int k = 0; k < 6; k++) push_byte(0, 8'(8'hC0 + k), (k == 5));
        wait_grants(g0 + 1, 50);
        push_byte(3, 8'hD3, 1'b1);
        wait_idle(400);
        wait_grants(g0 + 3, 10);
        chk("limit_grant0", 32'(grant_log[g0]),     32'd0);
        chk("limit_grant1", 32'(grant_log[g0 + 1]), 32'd3);
        chk("limit_grant2", 32'(grant_log[g0 + 2]), 32'd0);
        chk("overrun_count", 32'(ov_count - oc), 32'd1);

        // Randomized traffic with valid gaps and random UART readiness
        gaps_en  = 1'b1;
        rdy_rand = 1'b1;
        for (int m = 0; m < 40; m++) begin
            int r, len;
            r   = $urandom_range(0, NUM_REQ - 1);
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                b = 8'($urandom_range(0, 255));
                push_byte(r, b, (k == len - 1));
            end
            n = $urandom_range(0, 15);
            repeat (n) @(posedge clock);
        end
        wait_idle(20000);
        gaps_en  = 1'b0;
        rdy_rand = 1'b0;
        repeat (3) @(posedge clock);

        // Single-byte message from requester 2: header (if built) then payload
        wc = wr_count;
        push_byte(2, 8'h5A, 1'b1);
        wait_idle(200);
        n = wr_data.size();
        chk("hdr_msg_writes", 32'(wr_count - wc), 32'(1 + HDR_N));
        chk("hdr_msg_payload", 32'(wr_data[n-1]), 32'h5A);
        if (HDR_N != 0) chk("hdr_msg_header", 32'(wr_data[n-2]), 32'hA2);

        // Reset in the middle of a 5-byte message
        wc = wr_count;
        for (int k = 0; k < 5; k++) push_byte(0, 8'(8'hE0 + k), (k == 4));
        wait_writes(wc + 2 + HDR_N, 200);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stim_q[i].delete();
            exp_q[i].delete();
        end
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        g0 = grant_log.size();
        push_byte(2, 8'h72, 1'b1);
        push_byte(0, 8'h70, 1'b1);
        wait_idle(200);
        wait_grants(g0 + 2, 10);
        chk("post_reset_first", 32'(grant_log[g0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mv_uart_tx_arbiter
`default_nettype wire
